// File: rtl/control_seq.sv
// Registered control decoder with valid/ready issue, stall/flush handling,
// multi-cycle parity sequencing and sticky illegal-encoding detection.
module control_seq #(
    parameter int OPW        = 4,
    parameter int IW         = 9,
    parameter int PAR_CYCLES = 4,
    parameter int SW         = $clog2(PAR_CYCLES)
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [IW-1:0]  Instr,
    input  logic           InstrValid,
    output logic           InstrReady,
    input  logic           Stall,
    input  logic           Flush,
    output logic           CtrlValid,
    output logic           TruncatedReg,
    output logic           TruncPrefix,
    output logic           AbsBranch,
    output logic           RelBranch,
    output logic           BranchInvert,
    output logic           BranchFlag,
    output logic           MemWrite,
    output logic           RegWrite,
    output logic           MemToReg,
    output logic           ParityOp,
    output logic [1:0]     SecondOperand,
    output logic [OPW-1:0] ALUOp,
    output logic [SW-1:0]  ParStep,
    output logic           ParLast,
    output logic           IllegalOp,
    output logic           Busy
);

    // Handshake: Instr transfers on a rising edge where InstrValid && InstrReady;
    // the bundle is consumed by execute on any edge where CtrlValid && !Stall.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic           trunc_reg;
        logic           trunc_prefix;
        logic           abs_branch;
        logic           rel_branch;
        logic           branch_invert;
        logic           branch_flag;
        logic           mem_write;
        logic           reg_write;
        logic           mem_to_reg;
        logic           parity_op;
        logic [1:0]     second_op;
        logic [OPW-1:0] alu_op;
    } bundle_t;

    localparam logic [SW-1:0] LAST_STEP = SW'(PAR_CYCLES - 1);

    function automatic bundle_t idle_bundle();
        bundle_t b;
        b           = '0;
        b.second_op = 2'b01;
        return b;
    endfunction

    logic [2:0] opcode;
    logic [3:0] mode;
    logic       unused_instr_bits;

    assign opcode            = Instr[IW-1:IW-3];
    assign mode              = Instr[3:0];
    assign unused_instr_bits = ^Instr[IW-4:4];

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    bundle_t       bundle_q, bundle_d;
    logic [SW-1:0] step_q, step_d;
    logic          last_q, last_d;
    logic          illegal_q, illegal_d;

    bundle_t dec;
    logic    dec_illegal;
    logic    accept;

    // Pure instruction decode; illegal encodings collapse to an all-zero bubble.
    always_comb begin
        dec           = '0;
        dec.second_op = 2'b01;
        dec.reg_write = 1'b1;
        dec_illegal   = 1'b0;
        case (opcode)
            3'b000: dec.alu_op = OPW'(4'b0000);
            3'b001: dec.alu_op = OPW'(4'b0001);
            3'b010: dec.alu_op = OPW'(4'b0010);
            3'b011: begin
                dec.alu_op       = OPW'(4'b0001);
                dec.trunc_reg    = 1'b1;
                dec.trunc_prefix = 1'b0;
                dec.second_op    = 2'b00;
                if (mode[3]) begin
                    dec.mem_write = 1'b1;
                    dec.reg_write = 1'b0;
                end else begin
                    dec.mem_to_reg = 1'b1;
                end
            end
            3'b100: begin
                dec.alu_op       = OPW'(4'b0000);
                dec.trunc_reg    = 1'b1;
                dec.trunc_prefix = 1'b1;
                dec.second_op    = 2'b10;
            end
            3'b101: begin
                case (mode[2:0])
                    3'b000:  dec.alu_op = OPW'(4'b0100);
                    3'b010:  dec.alu_op = OPW'(4'b0101);
                    3'b011:  dec.alu_op = OPW'(4'b0011);
                    3'b100:  dec.alu_op = OPW'(4'b0110);
                    3'b110:  dec.alu_op = OPW'(4'b0111);
                    default: dec_illegal = 1'b1;
                endcase
            end
            3'b110: begin
                dec.reg_write     = 1'b0;
                dec.abs_branch    = mode[0];
                dec.rel_branch    = ~mode[0];
                dec.branch_flag   = mode[1];
                dec.branch_invert = mode[2];
            end
            default: begin
                dec.parity_op = 1'b1;
                dec.alu_op    = OPW'({1'b1, mode[2:0]});
            end
        endcase
        if (dec_illegal) begin
            dec = '0;
        end
    end

    assign InstrReady = Reset_n && (state_q == S_IDLE) && !Flush && (!valid_q || !Stall);
    assign accept     = InstrValid && InstrReady;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        bundle_d  = bundle_q;
        step_d    = step_q;
        last_d    = last_q;
        illegal_d = illegal_q;
        if (Flush) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            bundle_d = idle_bundle();
            step_d   = '0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        valid_d  = 1'b1;
                        bundle_d = dec;
                        step_d   = '0;
                        last_d   = 1'b0;
                        if (dec_illegal) begin
                            illegal_d = 1'b1;
                        end
                        // Parity results are only written back on the final micro-op.
                        if (dec.parity_op) begin
                            bundle_d.reg_write = 1'b0;
                            state_d            = S_SEQ;
                        end
                    end else if (!(valid_q && Stall)) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    if (!Stall) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            step_d  = '0;
                            last_d  = 1'b0;
                        end else begin
                            step_d = step_q + 1'b1;
                            if (step_d == LAST_STEP) begin
                                last_d             = 1'b1;
                                bundle_d.reg_write = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            bundle_q  <= idle_bundle();
            step_q    <= '0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            bundle_q  <= bundle_d;
            step_q    <= step_d;
            last_q    <= last_d;
            illegal_q <= illegal_d;
        end
    end

    assign CtrlValid     = valid_q;
    assign TruncatedReg  = bundle_q.trunc_reg;
    assign TruncPrefix   = bundle_q.trunc_prefix;
    assign AbsBranch     = bundle_q.abs_branch;
    assign RelBranch     = bundle_q.rel_branch;
    assign BranchInvert  = bundle_q.branch_invert;
    assign BranchFlag    = bundle_q.branch_flag;
    assign MemWrite      = bundle_q.mem_write;
    assign RegWrite      = bundle_q.reg_write;
    assign MemToReg      = bundle_q.mem_to_reg;
    assign ParityOp      = bundle_q.parity_op;
    assign SecondOperand = bundle_q.second_op;
    assign ALUOp         = bundle_q.alu_op;
    assign ParStep       = step_q;
    assign ParLast       = last_q;
    assign IllegalOp     = illegal_q;
    assign Busy          = (state_q == S_SEQ);

endmodule

// File: tb/tb_control_seq.sv
// Directed, table-driven bench for control_seq with hand-computed expected bundles.
module tb_control_seq;

    logic       Clk;
    logic       Reset_n;
    logic [8:0] Instr;
    logic       InstrValid;
    logic       InstrReady;
    logic       Stall;
    logic       Flush;
    logic       CtrlValid;
    logic       TruncatedReg, TruncPrefix, AbsBranch, RelBranch, BranchInvert;
    logic       BranchFlag, MemWrite, RegWrite, MemToReg, ParityOp;
    logic [1:0] SecondOperand;
    logic [3:0] ALUOp;
    logic [1:0] ParStep;
    logic       ParLast;
    logic       IllegalOp;
    logic       Busy;

    control_seq dut (
        .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .Stall(Stall), .Flush(Flush), .CtrlValid(CtrlValid),
        .TruncatedReg(TruncatedReg), .TruncPrefix(TruncPrefix), .AbsBranch(AbsBranch),
        .RelBranch(RelBranch), .BranchInvert(BranchInvert), .BranchFlag(BranchFlag),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg), .ParityOp(ParityOp),
        .SecondOperand(SecondOperand), .ALUOp(ALUOp), .ParStep(ParStep), .ParLast(ParLast),
        .IllegalOp(IllegalOp), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Check scope: 0 = CtrlValid/IllegalOp/Busy only, 1 = everything, 2 = all but SecondOperand
    typedef struct {
        string      name;
        logic [8:0] instr;
        logic       iv, st, fl;
        logic       rdy;
        int         scope;
        logic       cv;
        logic [9:0] ctl;   // {tr,tp,ab,rb,bi,bf,mw,rw,mr,po}
        logic [1:0] so;
        logic [3:0] alu;
        logic [1:0] step;
        logic       last, ill, busy;
    } vec_t;

    vec_t tbl[$];

    logic [8:0] I_ADD, I_STO, I_ADDI, I_AND, I_LOD, I_XOR, I_SH2, I_SH4;
    logic [8:0] I_BR3, I_BR5, I_PAR, I_ILL;
    logic [9:0] C_ALU, C_STO, C_ADDI, C_LOD, C_BR3, C_BR5, C_PAR, C_PARL, C_NONE;

    function automatic vec_t mk(string name, logic [8:0] instr, logic iv, logic st, logic fl,
                                logic rdy, int scope, logic cv, logic [9:0] ctl, logic [1:0] so,
                                logic [3:0] alu, logic [1:0] step, logic last, logic ill,
                                logic busy);
        vec_t v;
        v.name = name; v.instr = instr; v.iv = iv; v.st = st; v.fl = fl; v.rdy = rdy;
        v.scope = scope; v.cv = cv; v.ctl = ctl; v.so = so; v.alu = alu; v.step = step;
        v.last = last; v.ill = ill; v.busy = busy;
        return v;
    endfunction

    function automatic logic [21:0] got_word();
        return {CtrlValid, TruncatedReg, TruncPrefix, AbsBranch, RelBranch, BranchInvert,
                BranchFlag, MemWrite, RegWrite, MemToReg, ParityOp, SecondOperand, ALUOp,
                ParStep, ParLast, IllegalOp, Busy};
    endfunction

    task automatic check_word(string name, logic [21:0] exp, logic [21:0] mask);
        logic [21:0] got;
        got = got_word();
        tests_run++;
        if ((got & mask) !== (exp & mask)) begin
            tests_failed++;
            $display("FAIL %s: outputs got %h required %h (mask %h)", name, got & mask,
                     exp & mask, mask);
        end
    endtask

    task automatic check_ready(string name, logic exp);
        tests_run++;
        if (InstrReady !== exp) begin
            tests_failed++;
            $display("FAIL %s/rdy: InstrReady got %b required %b", name, InstrReady, exp);
        end
    endtask

    // Inputs change at posedge+1; ready sampled mid-cycle, outputs at next posedge+1.
    task automatic apply(vec_t v);
        logic [21:0] mask;
        Instr      = v.instr;
        InstrValid = v.iv;
        Stall      = v.st;
        Flush      = v.fl;
        #2;
        check_ready(v.name, v.rdy);
        @(posedge Clk);
        #1;
        case (v.scope)
            0:       mask = 22'b1_0000000000_00_0000_00_0_1_1;
            2:       mask = 22'b1_1111111111_00_1111_11_1_1_1;
            default: mask = '1;
        endcase
        check_word(v.name, {v.cv, v.ctl, v.so, v.alu, v.step, v.last, v.ill, v.busy}, mask);
    endtask

    task automatic check_reset_state(string name);
        check_word(name, {1'b0, 10'b0, 2'b01, 4'b0, 2'b0, 1'b0, 1'b0, 1'b0}, '1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_ADD  = 9'b000_000_001; I_STO = 9'b011_00_1000; I_ADDI = 9'b100_00_0111;
        I_AND  = 9'b010_00_0000; I_LOD = 9'b011_00_0000; I_XOR  = 9'b001_00_0000;
        I_SH2  = 9'b101_00_0010; I_SH4 = 9'b101_00_0100; I_BR3  = 9'b110_00_0011;
        I_BR5  = 9'b110_00_0101; I_PAR = 9'b111_00_0011; I_ILL  = 9'b101_00_0101;
        C_ALU  = 10'b0000000100; C_STO = 10'b1000001000; C_ADDI = 10'b1100000100;
        C_LOD  = 10'b1000000110; C_BR3 = 10'b0010010000; C_BR5  = 10'b0010100000;
        C_PAR  = 10'b0000000001; C_PARL = 10'b0000000101; C_NONE = 10'b0;

        // Back-to-back decode stream
        tbl.push_back(mk("add",  I_ADD,  1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0000, 0,0,0,0));
        tbl.push_back(mk("sto",  I_STO,  1,0,0, 1, 1, 1, C_STO,  2'b00, 4'b0001, 0,0,0,0));
        tbl.push_back(mk("addi", I_ADDI, 1,0,0, 1, 1, 1, C_ADDI, 2'b10, 4'b0000, 0,0,0,0));
        tbl.push_back(mk("and",  I_AND,  1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0010, 0,0,0,0));
        tbl.push_back(mk("lod",  I_LOD,  1,0,0, 1, 1, 1, C_LOD,  2'b00, 4'b0001, 0,0,0,0));
        tbl.push_back(mk("xor",  I_XOR,  1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0001, 0,0,0,0));
        tbl.push_back(mk("sh2",  I_SH2,  1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0101, 0,0,0,0));
        tbl.push_back(mk("sh4",  I_SH4,  1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0110, 0,0,0,0));
        tbl.push_back(mk("br3",  I_BR3,  1,0,0, 1, 1, 1, C_BR3,  2'b01, 4'b0000, 0,0,0,0));
        tbl.push_back(mk("drain",I_ADD,  0,0,0, 1, 0, 0, C_NONE, 2'b01, 4'b0000, 0,0,0,0));
        // Parity with a stall on step 1: steps 0,1,1,2,3
        tbl.push_back(mk("par0", I_PAR,  1,0,0, 1, 1, 1, C_PAR,  2'b01, 4'b1011, 0,0,0,1));
        tbl.push_back(mk("par1", I_ADD,  1,0,0, 0, 1, 1, C_PAR,  2'b01, 4'b1011, 1,0,0,1));
        tbl.push_back(mk("par1s",I_ADD,  1,1,0, 0, 1, 1, C_PAR,  2'b01, 4'b1011, 1,0,0,1));
        tbl.push_back(mk("par2", I_ADD,  1,0,0, 0, 1, 1, C_PAR,  2'b01, 4'b1011, 2,0,0,1));
        tbl.push_back(mk("par3", I_ADD,  1,0,0, 0, 1, 1, C_PARL, 2'b01, 4'b1011, 3,1,0,1));
        tbl.push_back(mk("pardn",I_ADD,  1,0,0, 0, 0, 0, C_NONE, 2'b01, 4'b0000, 0,0,0,0));
        tbl.push_back(mk("paradd",I_ADD, 1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0000, 0,0,0,0));
        // Branch held under a 5-cycle stall, released into an accept
        tbl.push_back(mk("br5",  I_BR5,  1,0,0, 1, 1, 1, C_BR5,  2'b01, 4'b0000, 0,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("br5hold", I_ADD, 1,1,0, 0, 1, 1, C_BR5, 2'b01, 4'b0000, 0,0,0,0));
        tbl.push_back(mk("br5rel",I_ADD, 1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0000, 0,0,0,0));
        // Flush at ParStep=1 with a valid instruction waiting
        tbl.push_back(mk("fpar0",I_PAR,  1,0,0, 1, 1, 1, C_PAR,  2'b01, 4'b1011, 0,0,0,1));
        tbl.push_back(mk("fpar1",I_ADD,  1,0,0, 0, 1, 1, C_PAR,  2'b01, 4'b1011, 1,0,0,1));
        tbl.push_back(mk("flush",I_ADD,  1,0,1, 0, 2, 0, C_NONE, 2'b01, 4'b0000, 0,0,0,0));
        tbl.push_back(mk("fresume",I_AND,1,0,0, 1, 1, 1, C_ALU,  2'b01, 4'b0010, 0,0,0,0));

        Reset_n = 1'b0; Instr = '0; InstrValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_ready("reset", 1'b0);
        check_reset_state("reset");
        Reset_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Illegal shift becomes a bubble; IllegalOp sticks until reset
        apply(mk("illegal", I_ILL, 1,0,0, 1, 1, 1, C_NONE, 2'b00, 4'b0000, 0,0,1,0));
        for (int i = 0; i < 10; i++)
            apply(mk("ill_sticky", I_ADD, 1,0,0, 1, 1, 1, C_ALU, 2'b01, 4'b0000, 0,0,1,0));
        Reset_n = 1'b0; InstrValid = 1'b0;
        #1;
        check_ready("ill_rst", 1'b0);
        @(posedge Clk);
        #1;
        check_reset_state("ill_rst");
        Reset_n = 1'b1;

        // Reset while sequencing and stalled aborts the parity op
        apply(mk("rpar0", I_PAR, 1,0,0, 1, 1, 1, C_PAR, 2'b01, 4'b1011, 0,0,0,1));
        apply(mk("rpar1", I_ADD, 0,0,0, 0, 1, 1, C_PAR, 2'b01, 4'b1011, 1,0,0,1));
        Reset_n = 1'b0; Stall = 1'b1; InstrValid = 1'b1; Instr = I_ADD;
        #1;
        check_ready("seq_rst", 1'b0);
        @(posedge Clk);
        #1;
        check_reset_state("seq_rst");
        Reset_n = 1'b1; InstrValid = 1'b0;
        #1;
        check_ready("post_rst", 1'b1);
        Stall = 1'b0;
        @(posedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
